// File: rtl/ls_unit.sv
// Load/store sequencer between a datapath and a single-port-per-direction data memory.
// Stores hold dm_we for WE_CYCLES clocks and keep address/data one extra cycle after it falls.
module ls_unit #(
  parameter int WE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [15:0] dm_read_addr,
  output logic [15:0] dm_write_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_we,
  input  logic [31:0] dm_read_data,
  output logic [15:0] ld_count,
  output logic [15:0] st_count
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_PULSE, WR_HOLD, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  we_cnt_q, we_cnt_d;
  logic        dm_we_q, dm_we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] ld_q, ld_d;
  logic [15:0] st_q, st_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_cnt_q    <= 4'd0;
      dm_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      addr_q      <= 16'd0;
      wdata_q     <= 32'd0;
      ld_q        <= 16'd0;
      st_q        <= 16'd0;
    end else begin
      state_q     <= state_d;
      we_cnt_q    <= we_cnt_d;
      dm_we_q     <= dm_we_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ld_q        <= ld_d;
      st_q        <= st_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_cnt_d    = we_cnt_q;
    dm_we_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ld_d        = ld_q;
    st_d        = st_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (req_wr) begin
            wdata_d  = req_wdata;
            dm_we_d  = 1'b1;
            we_cnt_d = 4'(WE_CYCLES);
            state_d  = WR_PULSE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rdata_d     = dm_read_data;
        rsp_valid_d = 1'b1;
        ld_d        = ld_q + 16'd1;
        state_d     = DONE;
      end
      WR_PULSE: begin
        // Counter holds the cycles of dm_we still owed, including the current one.
        if (we_cnt_q <= 4'd1) begin
          we_cnt_d = 4'd0;
          state_d  = WR_HOLD;
        end else begin
          dm_we_d  = 1'b1;
          we_cnt_d = we_cnt_q - 4'd1;
        end
      end
      WR_HOLD: begin
        rsp_valid_d = 1'b1;
        st_d        = st_q + 16'd1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE) && !rst;
    rsp_valid     = rsp_valid_q;
    rsp_rdata     = rdata_q;
    dm_read_addr  = addr_q;
    dm_write_addr = addr_q;
    dm_write_data = wdata_q;
    dm_we         = dm_we_q;
    ld_count      = ld_q;
    st_count      = st_q;
  end

endmodule
